// File: rtl/demapper_if.sv
// Symbol-group input and decoded-word output bundle of the RX demapper.
interface demapper_if #(
    parameter int CNT_W = 16
);
    logic             rx_valid;
    logic [6:0]       rx_rotation;
    logic [6:0]       rx_polarity;
    logic [6:0]       rx_flip;
    logic             err_cnt_clr;
    logic [15:0]      rx_data;
    logic             rx_data_valid;
    logic [1:0]       rx_err;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;

    modport master (
        output rx_valid, rx_rotation, rx_polarity, rx_flip, err_cnt_clr,
        input  rx_data, rx_data_valid, rx_err, err_cnt, err_sticky
    );

    modport slave (
        input  rx_valid, rx_rotation, rx_polarity, rx_flip, err_cnt_clr,
        output rx_data, rx_data_valid, rx_err, err_cnt, err_sticky
    );
endinterface

// File: rtl/demapper.sv
// RX demapper: rebuilds the 16-bit word from a 7-lane rotation/polarity/flip
// symbol group through a 2-stage pipeline, with error flags and counter.
module demapper_lane (
    input  logic       rot,
    input  logic       pol,
    input  logic       flip,
    output logic [1:0] pair,
    output logic       bad
);
    assign pair = {rot, pol};
    // a flipped lane is expected to be idle
    assign bad  = flip & (rot | pol);
endmodule

module demapper #(
    parameter int CNT_W = 16
) (
    input logic       clk,
    input logic       rst_n,
    demapper_if.slave bus
);
    localparam int NUM_LANES = 7;
    localparam int STAGES    = 2;

    typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_TWO, CLS_ILL} cls_e;

    typedef struct packed {
        logic [NUM_LANES-1:0] rot;
        logic [NUM_LANES-1:0] pol;
        logic [NUM_LANES-1:0] flip;
        cls_e                 cls;
        logic [2:0]           lo;
        logic [2:0]           hi;
    } s1_t;

    logic [STAGES:0]           vld_pipe;
    s1_t                       s1_d, s1_q;
    logic [2:0]                pop;
    logic [NUM_LANES-1:0][1:0] pair;
    logic [NUM_LANES-1:0]      bad;
    logic [NUM_LANES-1:0][1:0] comp;
    logic [2:0]                pos;
    logic [5:0]                two_code;
    logic [15:0]               data_d, data_q;
    logic [1:0]                err_d, err_q;
    logic                      err_word;
    logic [CNT_W-1:0]          cnt_q;
    logic                      sticky_q;

    // lexicographic index of the first pair whose lower lane is i
    function automatic logic [5:0] pair_base(input logic [2:0] i);
        case (i)
            3'd0:    return 6'd0;
            3'd1:    return 6'd6;
            3'd2:    return 6'd11;
            3'd3:    return 6'd15;
            3'd4:    return 6'd18;
            default: return 6'd20;
        endcase
    endfunction

    assign vld_pipe[0] = bus.rx_valid;

    always_comb begin
        pop = '0;
        s1_d.lo = '0;
        s1_d.hi = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--)
            if (bus.rx_flip[k]) s1_d.lo = 3'(k);
        for (int k = 0; k < NUM_LANES; k++) begin
            pop = pop + 3'(bus.rx_flip[k]);
            if (bus.rx_flip[k]) s1_d.hi = 3'(k);
        end
        s1_d.rot  = bus.rx_rotation;
        s1_d.pol  = bus.rx_polarity;
        s1_d.flip = bus.rx_flip;
        case (pop)
            3'd0:    s1_d.cls = CLS_NONE;
            3'd1:    s1_d.cls = CLS_ONE;
            3'd2:    s1_d.cls = (bus.rx_flip == 7'h60) ? CLS_ILL : CLS_TWO;
            default: s1_d.cls = CLS_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            s1_q               <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (bus.rx_valid) s1_q <= s1_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demapper_lane u_lane (
            .rot  (s1_q.rot[g]),
            .pol  (s1_q.pol[g]),
            .flip (s1_q.flip[g]),
            .pair (pair[g]),
            .bad  (bad[g])
        );
    end

    // pack the pairs of non-flipped lanes downward, lowest lane first
    always_comb begin
        comp = '0;
        pos  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!s1_q.flip[k]) begin
                comp[pos] = pair[k];
                pos       = pos + 3'd1;
            end
        end
    end

    assign two_code = 6'h2C + pair_base(s1_q.lo) + {3'b000, s1_q.hi}
                      - {3'b000, s1_q.lo} - 6'd1;

    always_comb begin
        data_d = '0;
        err_d  = {|bad, 1'b0};
        case (s1_q.cls)
            CLS_NONE: data_d = {2'b00, comp};
            CLS_ONE:  data_d = {4'h4 + {1'b0, s1_q.lo}, comp[5:0]};
            CLS_TWO:  data_d = {two_code, comp[4:0]};
            default: begin
                data_d = '0;
                err_d  = 2'b01;
            end
        endcase
    end

    assign err_word = vld_pipe[1] && (err_d != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (vld_pipe[1]) begin
                data_q <= data_d;
                err_q  <= err_d;
            end else begin
                err_q  <= '0;
            end
            if (bus.err_cnt_clr)
                cnt_q <= err_word ? CNT_W'(1) : '0;
            else if (err_word && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
            if (err_word)
                sticky_q <= 1'b1;
            else if (bus.err_cnt_clr)
                sticky_q <= 1'b0;
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_data_valid = vld_pipe[STAGES];
    assign bus.rx_err        = err_q;
    assign bus.err_cnt       = cnt_q;
    assign bus.err_sticky    = sticky_q;
endmodule
